// File: rtl/result_display_driver_if.sv
// rtl/result_display_driver_if.sv - load/result handshake between the arithmetic unit and the display driver
interface result_display_driver_if;
   logic [7:0]  value;
   logic        flag;
   logic        load;
   logic        busy;
   logic        done;
   logic [11:0] bcd;
   logic        led;

   modport master (output value, flag, load, input busy, done, bcd, led);
   modport slave  (input value, flag, load, output busy, done, bcd, led);
endinterface

// File: rtl/result_display_driver.sv
// rtl/result_display_driver.sv - captures an 8-bit result, converts it to BCD by double-dabble
// and scans it onto a 4-digit multiplexed seven-segment display with a status LED
module result_display_driver #(
   parameter int SCAN_DIV       = 50000,
   parameter bit ACTIVE_LOW_SEG = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   result_display_driver_if.slave   bus,
   output logic [6:0]               seg,
   output logic [3:0]               an
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ADJ   = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [1:0]    state;
   logic [7:0]    shreg;
   logic          flag_r;
   logic [11:0]   acc;
   logic [3:0]    count;
   logic [CW-1:0] scan_cnt;
   logic [1:0]    idx;
   logic          wrap;
   logic [1:0]    idx_next;
   logic [11:0]   bcd_next;

   function automatic logic [3:0] adj3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] polarity(input logic [6:0] p);
      return ACTIVE_LOW_SEG ? ~p : p;
   endfunction

   function automatic logic [6:0] digit_pattern(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b1111110;
         4'd1:    p = 7'b0110000;
         4'd2:    p = 7'b1101101;
         4'd3:    p = 7'b1111001;
         4'd4:    p = 7'b0110011;
         4'd5:    p = 7'b1011011;
         4'd6:    p = 7'b1011111;
         4'd7:    p = 7'b1110000;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1111011;
         default: p = 7'b0000000;
      endcase
      return polarity(p);
   endfunction

   // Leading zeros are blanked; the ones digit is always lit, digit 3 never is.
   function automatic logic [6:0] digit_seg(input logic [1:0] i, input logic [11:0] b);
      logic [6:0] s;
      case (i)
         2'd0:    s = digit_pattern(b[3:0]);
         2'd1:    s = (b[11:4] == 8'd0) ? polarity(7'b0000000) : digit_pattern(b[7:4]);
         2'd2:    s = (b[11:8] == 4'd0) ? polarity(7'b0000000) : digit_pattern(b[11:8]);
         default: s = polarity(7'b0000000);
      endcase
      return s;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= 8'd0;
         flag_r   <= 1'b0;
         acc      <= 12'd0;
         count    <= 4'd0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.bcd  <= 12'd0;
         bus.led  <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.load) begin
                  shreg    <= bus.value;
                  flag_r   <= bus.flag;
                  acc      <= 12'd0;
                  count    <= 4'd0;
                  bus.busy <= 1'b1;
                  state    <= ADJ;
               end
            end
            ADJ: begin
               acc   <= {adj3(acc[11:8]), adj3(acc[7:4]), adj3(acc[3:0])};
               state <= SHIFT;
            end
            SHIFT: begin
               {acc, shreg} <= {acc[10:0], shreg, 1'b0};
               count        <= count + 4'd1;
               state        <= (count == 4'd7) ? DONE : ADJ;
            end
            DONE: begin
               bus.bcd  <= acc;
               bus.led  <= flag_r;
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // seg/an are computed from the post-edge index and bcd so they track a bcd update without lag.
   assign wrap     = (scan_cnt == CW'(SCAN_DIV - 1));
   assign idx_next = wrap ? idx + 2'd1 : idx;
   assign bcd_next = (state == DONE) ? acc : bus.bcd;

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= 2'd0;
         an       <= 4'b1110;
         seg      <= digit_pattern(4'd0);
      end else begin
         scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
         idx      <= idx_next;
         an       <= ~(4'b0001 << idx_next);
         seg      <= digit_seg(idx_next, bcd_next);
      end
   end

endmodule

// File: tb/tb_result_display_driver.sv
// tb/tb_result_display_driver.sv - scoreboard bench for result_display_driver
module tb_result_display_driver;

   logic clk = 1'b0;
   logic rst;
   logic [6:0] seg;
   logic [3:0] an;

   always #5 clk = ~clk;

   result_display_driver_if io();

   result_display_driver #(.SCAN_DIV(4), .ACTIVE_LOW_SEG(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (io),
      .seg (seg),
      .an  (an)
   );

   int vectors = 0;
   int miscompares = 0;
   int ecount = 0;
   logic [12:0] sbq[$];
   logic [12:0] exp_entry;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Edges since reset released; the scan counter should follow it exactly.
   always @(posedge clk) begin
      if (rst) ecount <= 0;
      else     ecount <= ecount + 1;
   end

   always @(posedge clk) begin
      #1;
      if (io.done === 1'b1) begin
         if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done=1 bcd=%0h expected no done", io.bcd);
         end else begin
            exp_entry = sbq.pop_front();
            check("done_bcd", {20'd0, io.bcd}, {20'd0, exp_entry[11:0]});
            check("done_led", {31'd0, io.led}, {31'd0, exp_entry[12]});
         end
      end
   end

   function automatic logic [6:0] digit_al(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input int i, input logic [11:0] b);
      case (i)
         0:       return digit_al(b[3:0]);
         1:       return (b[11:4] == 8'd0) ? 7'b1111111 : digit_al(b[7:4]);
         2:       return (b[11:8] == 4'd0) ? 7'b1111111 : digit_al(b[11:8]);
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic disp_check(input logic [11:0] b, input int n);
      logic [3:0] one;
      int k;
      one = 4'b0001;
      for (int c = 0; c < n; c++) begin
         tick();
         k = (ecount / 4) % 4;
         check("scan_an", {28'd0, an}, {28'd0, ~(one << k)});
         check("scan_seg", {25'd0, seg}, {25'd0, exp_seg(k, b)});
      end
   endtask

   task automatic issue(input logic [7:0] v, input logic f, input logic [11:0] exp_bcd, input bit push);
      io.value = v;
      io.flag  = f;
      io.load  = 1'b1;
      if (push) sbq.push_back({f, exp_bcd});
      tick();
      io.load  = 1'b0;
   endtask

   task automatic wait_done();
      check("busy_rise", {31'd0, io.busy}, 32'd1);
      for (int k = 1; k <= 16; k++) begin
         tick();
         check("busy_hold", {31'd0, io.busy}, 32'd1);
         check("done_early", {31'd0, io.done}, 32'd0);
      end
      tick();
      check("done_at_17", {31'd0, io.done}, 32'd1);
      check("busy_fall", {31'd0, io.busy}, 32'd0);
   endtask

   logic [7:0]  tv_val [3] = '{8'd0,   8'd99,   8'd128};
   logic        tv_flg [3] = '{1'b1,   1'b1,    1'b0};
   logic [11:0] tv_bcd [3] = '{12'h000, 12'h099, 12'h128};

   initial begin
      rst      = 1'b1;
      io.load  = 1'b0;
      io.value = 8'd0;
      io.flag  = 1'b0;
      repeat (2) tick();
      check("rst_busy", {31'd0, io.busy}, 32'd0);
      check("rst_done", {31'd0, io.done}, 32'd0);
      check("rst_bcd", {20'd0, io.bcd}, 32'h000);
      check("rst_led", {31'd0, io.led}, 32'd0);
      check("rst_an", {28'd0, an}, 32'b1110);
      check("rst_seg", {25'd0, seg}, 32'b0000001);
      rst = 1'b0;

      issue(8'd255, 1'b1, 12'h255, 1'b1);
      wait_done();
      check("full_bcd", {20'd0, io.bcd}, 32'h255);
      disp_check(12'h255, 16);

      issue(8'd7, 1'b0, 12'h007, 1'b1);
      wait_done();
      disp_check(12'h007, 16);

      // Second load lands mid-conversion and must be dropped; the load in the done cycle is taken.
      issue(8'd100, 1'b0, 12'h100, 1'b1);
      repeat (4) tick();
      issue(8'd42, 1'b1, 12'h000, 1'b0);
      repeat (11) tick();
      check("ignore_busy", {31'd0, io.busy}, 32'd1);
      tick();
      check("ignore_done", {31'd0, io.done}, 32'd1);
      check("ignore_bcd", {20'd0, io.bcd}, 32'h100);
      issue(8'd42, 1'b0, 12'h042, 1'b1);
      wait_done();

      issue(8'd200, 1'b1, 12'h000, 1'b0);
      repeat (7) tick();
      rst      = 1'b1;
      io.load  = 1'b1;
      io.value = 8'd9;
      tick();
      rst      = 1'b0;
      io.load  = 1'b0;
      check("abort_busy", {31'd0, io.busy}, 32'd0);
      check("abort_bcd", {20'd0, io.bcd}, 32'h000);
      check("abort_led", {31'd0, io.led}, 32'd0);
      disp_check(12'h000, 24);
      check("abort_idle", {31'd0, io.busy}, 32'd0);
      issue(8'd50, 1'b0, 12'h050, 1'b1);
      wait_done();

      for (int t = 0; t < 3; t++) begin
         issue(tv_val[t], tv_flg[t], tv_bcd[t], 1'b1);
         wait_done();
      end
      disp_check(12'h128, 8);

      repeat (2) tick();
      check("queue_empty", sbq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
